// File: rtl/fifo_pattern_writer.sv
// Burst pattern generator: writes an incrementing sequence into a FIFO.
// Optional checksum accumulator enabled by FIFO_PATTERN_CHECKSUM_EN.
module fifo_pattern_writer #(
  parameter int DATA_W     = 8,
  parameter int BURST_LEN  = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              busy,
  output logic [15:0]       words_written,
  output logic [15:0]       checksum
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [7:0] LP_BURST_LAST = 8'(BURST_LEN - 1);
  localparam logic [7:0] LP_GAP_LAST   = 8'(GAP_CYCLES - 1);
  localparam bit         LP_HAS_GAP    = (GAP_CYCLES != 0);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_seq;
  logic [7:0]        r_burst_cnt;
  logic [7:0]        r_gap_cnt;
  logic [15:0]       r_words;
  logic              w_wr_en;
  logic              w_burst_last;
  logic              w_gap_last;
  logic              w_in_gap;

  // Write strobe; reset low suppresses it even before the state clears.
  assign w_wr_en = (r_state == ST_BURST) && !fifo_full && reset_n;
  assign w_burst_last = w_wr_en && (r_burst_cnt == LP_BURST_LAST);
  assign w_in_gap = (r_state == ST_GAP);
  assign w_gap_last = w_in_gap && (r_gap_cnt == LP_GAP_LAST);

  // Next-state selection; a started burst always runs to completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (w_burst_last) begin
          if (LP_HAS_GAP)  w_state_nxt = ST_GAP;
          else if (enable) w_state_nxt = ST_BURST;
          else             w_state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (w_gap_last) begin
          w_state_nxt = enable ? ST_BURST : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Sequence value carries across bursts and only moves on a write.
  always_ff @(posedge clk) begin
    if (!reset_n)     r_seq <= '0;
    else if (w_wr_en) r_seq <= r_seq + 1'b1;
  end

  // Words written in the current burst.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_burst_cnt <= '0;
    end else if (w_wr_en) begin
      if (w_burst_last) r_burst_cnt <= '0;
      else              r_burst_cnt <= r_burst_cnt + 8'd1;
    end
  end

  // Idle cycles spent in the current gap.
  always_ff @(posedge clk) begin
    if (!reset_n)        r_gap_cnt <= '0;
    else if (w_gap_last) r_gap_cnt <= '0;
    else if (w_in_gap)   r_gap_cnt <= r_gap_cnt + 8'd1;
    else                 r_gap_cnt <= '0;
  end

  // Total accepted writes, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (!reset_n)     r_words <= '0;
    else if (w_wr_en) r_words <= r_words + 16'd1;
  end

`ifdef FIFO_PATTERN_CHECKSUM_EN
  logic [15:0] r_checksum;

  // Running sum of every word handed to the FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n)     r_checksum <= '0;
    else if (w_wr_en) r_checksum <= r_checksum + 16'(r_seq);
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign fifo_wr_en    = w_wr_en;
  assign fifo_wdata    = r_seq;
  assign busy          = (r_state != ST_IDLE);
  assign words_written = r_words;

endmodule
